sync_fifo_flagged: RTL and testbench
====================================

// Module: sync_fifo_flagged
// PURPOSE
//  Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO.
//  Adds programmable almost-full/almost-empty thresholds, an occupancy count,
//  sticky overflow/underflow error flags and a selectable first-word-fall-through read mode.
//  Sits between a producer and a consumer in the same clock domain; drop-in for the 8x8 FIFO.
// PARAMETERS
//  WIDTH      8        data word width in bits (>=1)
//  DEPTH      8        number of entries (>=2, need not be a power of 2)
//  AF_THRESH  DEPTH-2  almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2        almost_empty asserted when count <= AE_THRESH
//  FWFT       0        0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1                  clock, all state on rising edge
//  rst           in   1                  asynchronous, active-high reset
//  wr_en         in   1                  write request
//  rd_en         in   1                  read request
//  data_in       in   WIDTH              write data
//  clr_err       in   1                  synchronous clear of overflow/underflow
//  data_out      out  WIDTH              read data
//  full          out  1                  count == DEPTH
//  empty         out  1                  count == 0
//  almost_full   out  1                  count >= AF_THRESH
//  almost_empty  out  1                  count <= AE_THRESH
//  count         out  $clog2(DEPTH+1)    current occupancy, 0..DEPTH
//  overflow      out  1                  sticky: write attempted while full
//  underflow     out  1                  sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async assert, immediate, also mid-operation): wr_ptr=rd_ptr=0, count=0, empty=1,
//    full=0, almost_empty=1, almost_full=0, data_out=0, overflow=underflow=0. Memory not reset.
//  - wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty (both judged on pre-edge registered flags).
//  - wr_ok: mem[wr_ptr]<=data_in, wr_ptr advances. rd_ok: rd_ptr advances.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (non-power-of-2 DEPTH supported).
//  - count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
//  - Simultaneous wr_en & rd_en: when full -> read only (write dropped, overflow set);
//    when empty -> write only (underflow set); otherwise both, count unchanged.
//  - All four status flags registered, derived from next count; update on same edge as count.
//  - FWFT=0: on rd_ok, data_out <= mem[rd_ptr] at that edge (1-cycle latency); otherwise holds.
//  - FWFT=1: data_out = mem[rd_ptr] whenever ~empty (head visible with no rd_en); 0 while empty.
//    First write into empty FIFO visible on data_out the cycle after the write edge.
//  - overflow <= 1 when wr_en & full; underflow <= 1 when rd_en & empty; both cleared by
//    clr_err; set wins over clr_err in the same cycle. Dropped accesses change no other state.
//  - Elaboration error if DEPTH<2 or not (0 <= AE_THRESH < AF_THRESH <= DEPTH).
// TESTING  (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2 unless noted)
//  - Fill: 8 writes 0x10..0x17 -> count 1..8; almost_empty drops at count 3, almost_full at 6,
//    full at 8; 9th write 0xFF -> dropped, overflow=1, count stays 8.
//  - Drain (FWFT=0): 8 reads -> data_out 0x10..0x17, each one cycle after its rd_en edge;
//    empty=1 after 8th; extra read -> underflow=1, data_out holds 0x17.
//  - Wrap: 6 writes, 6 reads, repeated 3 times with data 0x00..0x11 -> order preserved
//    across pointer wrap, count returns to 0 each round.
//  - Simultaneous: at count=4, wr_en&rd_en for 5 cycles -> count stays 4, FIFO order kept;
//    at full, both -> count 7, overflow=1; at empty, both -> count 1, underflow=1.
//  - FWFT=1, DEPTH=5: write 0xA5 into empty -> data_out=0xA5 next cycle with no rd_en;
//    read -> data_out=0, empty=1.
//  - Async rst asserted mid-burst at count=5 with overflow=1 -> all outputs to reset values
//    before next edge; clr_err with overflow set and no full write -> overflow=0 next cycle.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, registered almost-full/almost-empty flags,
// sticky overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo_flagged #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WIDTH < 1 || DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH)
  begin : g_param_check
    $error("sync_fifo_flagged: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             wr_ok;
  logic             rd_ok;

  // Explicit wrap so that non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_THRESH));
      almost_empty <= (count_next <= CW'(AE_THRESH));
      // A new error event takes priority over a clear in the same cycle.
      if (wr_en & full)      overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (rd_en & empty)     underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        dout_q <= '0;
      else if (rd_ok) dout_q <= mem[rd_ptr];
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: a standard 8-deep instance and a 5-deep FWFT instance
// driven together and compared against queue-based reference models.
module tb_sync_fifo_flagged;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       clr_err = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       full_a, empty_a, af_a, ae_a, ov_a, un_a;
  logic       full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [3:0] cnt_a;
  logic [2:0] cnt_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_dout_a = '0;
  logic       exp_ov_a = 1'b0, exp_un_a = 1'b0;
  logic       exp_ov_b = 1'b0, exp_un_b = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flagged #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .clr_err(clr_err),
    .data_out(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(cnt_a), .overflow(ov_a), .underflow(un_a));

  sync_fifo_flagged #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .clr_err(clr_err),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(cnt_b), .overflow(ov_b), .underflow(un_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("a_count", 32'(cnt_a), qa.size());
    chk("a_full", 32'(full_a), 32'(qa.size() == 8));
    chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
    chk("a_almost_full", 32'(af_a), 32'(qa.size() >= 6));
    chk("a_almost_empty", 32'(ae_a), 32'(qa.size() <= 2));
    chk("a_overflow", 32'(ov_a), 32'(exp_ov_a));
    chk("a_underflow", 32'(un_a), 32'(exp_un_a));
    chk("a_data_out", 32'(dout_a), 32'(exp_dout_a));
    chk("b_count", 32'(cnt_b), qb.size());
    chk("b_full", 32'(full_b), 32'(qb.size() == 5));
    chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
    chk("b_almost_full", 32'(af_b), 32'(qb.size() >= 3));
    chk("b_almost_empty", 32'(ae_b), 32'(qb.size() <= 1));
    chk("b_overflow", 32'(ov_b), 32'(exp_ov_b));
    chk("b_underflow", 32'(un_b), 32'(exp_un_b));
    chk("b_data_out", 32'(dout_b), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_dout_a = '0;
    exp_ov_a = 1'b0; exp_un_a = 1'b0;
    exp_ov_b = 1'b0; exp_un_b = 1'b0;
  endtask

  // One clock of stimulus; the models step on the same edge using pre-edge occupancy.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic c);
    bit fa, ea, fb, eb;
    wr_en = w; rd_en = r; data_in = d; clr_err = c;
    @(posedge clk);
    fa = (qa.size() == 8); ea = (qa.size() == 0);
    fb = (qb.size() == 5); eb = (qb.size() == 0);
    if (r && !ea) exp_dout_a = qa.pop_front();
    if (w && !fa) qa.push_back(d);
    if (r && !eb) void'(qb.pop_front());
    if (w && !fb) qb.push_back(d);
    if (w && fa) exp_ov_a = 1'b1; else if (c) exp_ov_a = 1'b0;
    if (r && ea) exp_un_a = 1'b1; else if (c) exp_un_a = 1'b0;
    if (w && fb) exp_ov_b = 1'b1; else if (c) exp_ov_b = 1'b0;
    if (r && eb) exp_un_b = 1'b1; else if (c) exp_un_b = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    int p;
    #12;
    check_all();
    rst = 1'b0;

    // Fill, overflow, drain, underflow, then clear both error flags.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(r * 6 + i), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Simultaneous access at mid level, at full and at empty.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a cycle at count 5 with overflow set.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("a_count_before_rst", 32'(cnt_a), 32'd5);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;

    // Fall-through head visibility on the 5-deep instance.
    cycle(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("b_fwft_head", 32'(dout_b), 32'hA5);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Clearing overflow without a new write to a full FIFO.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Random traffic alternating between fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      p = ((i / 40) % 2 != 0) ? 30 : 70;
      cycle($urandom_range(0, 99) < p, $urandom_range(0, 99) < (100 - p),
            8'($urandom), $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
